// File: rtl/alu_result_select.sv
// Result-select stage: picks one of NUM_IN ALU result channels and buffers it in a
// 2-entry valid/ready FIFO, flagging and counting out-of-range selects.
module alu_result_select #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 5,
    parameter int SEL_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [7:0]              err_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // One extra bit so NUM_IN == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0] NUM_IN_L = (SEL_W + 1)'(NUM_IN);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] head_data_q, head_data_d;
    logic             head_err_q, head_err_d;
    logic [WIDTH-1:0] tail_data_q, tail_data_d;
    logic             tail_err_q, tail_err_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0] new_data;
    logic             new_err;
    logic             accept;
    logic             pop;

    // An out-of-range sel matches no channel, so new_data stays zero.
    always_comb begin
        // NOTE: assign every always_comb output a default first, or a path that skips it infers a latch.
        new_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                new_data = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign new_err   = ({1'b0, sel} >= NUM_IN_L);

    // in_ready is gated by rst so nothing can be accepted while reset is held.
    assign in_ready  = !rst && (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out       = head_data_q;
    assign out_err   = out_valid && head_err_q;
    assign err_cnt   = err_cnt_q;

    always_comb begin
        state_d     = state_q;
        head_data_d = head_data_q;
        head_err_d  = head_err_q;
        tail_data_d = tail_data_q;
        tail_err_d  = tail_err_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    state_d     = ST_ONE;
                    head_data_d = new_data;
                    head_err_d  = new_err;
                end
            end
            ST_ONE: begin
                if (accept && pop) begin
                    head_data_d = new_data;
                    head_err_d  = new_err;
                end else if (accept) begin
                    state_d     = ST_FULL;
                    tail_data_d = new_data;
                    tail_err_d  = new_err;
                end else if (pop) begin
                    // Head data is kept so out holds its last value while empty.
                    state_d     = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop) begin
                    state_d     = ST_ONE;
                    head_data_d = tail_data_q;
                    head_err_d  = tail_err_q;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    assign err_cnt_d = err_cnt_q + 8'((accept && new_err && (err_cnt_q != 8'hFF)) ? 1 : 0);

    // NOTE: the entry registers are reset as well, because out must read zero while rst is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            head_data_q <= '0;
            head_err_q  <= 1'b0;
            tail_data_q <= '0;
            tail_err_q  <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            head_data_q <= head_data_d;
            head_err_q  <= head_err_d;
            tail_data_q <= tail_data_d;
            tail_err_q  <= tail_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_alu_result_select.sv
// Self-checking bench for alu_result_select: directed scenarios plus random traffic,
// compared every cycle against a queue-based FIFO reference model.
module tb_alu_result_select;

    localparam int WIDTH  = 32;
    localparam int NUM_IN = 5;
    localparam int SEL_W  = 3;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out;
    logic                    out_err;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              err_cnt;

    always #5 clk = ~clk;

    alu_result_select #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_bus    (in_bus),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             err;
    } entry_t;

    entry_t           model_q[$];
    logic [WIDTH-1:0] last_out;
    int               exp_err_cnt;
    int               n_checks;
    int               n_fails;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_IN*WIDTH-1:0] bus_of(input int base);
        logic [NUM_IN*WIDTH-1:0] b;
        for (int k = 0; k < NUM_IN; k++) b[k*WIDTH +: WIDTH] = WIDTH'(base + k);
        return b;
    endfunction

    function automatic logic [NUM_IN*WIDTH-1:0] rand_bus();
        logic [NUM_IN*WIDTH-1:0] b;
        for (int k = 0; k < NUM_IN; k++) b[k*WIDTH +: WIDTH] = $urandom;
        return b;
    endfunction

    task automatic check_outputs(input string tag);
        logic nonempty;
        nonempty = (model_q.size() > 0);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(nonempty));
        check({tag, ".in_ready"},  64'(in_ready),  64'(model_q.size() < 2));
        check({tag, ".out"},       64'(out),       64'(nonempty ? model_q[0].data : last_out));
        check({tag, ".out_err"},   64'(out_err),   64'(nonempty ? model_q[0].err : 1'b0));
        check({tag, ".err_cnt"},   64'(err_cnt),   64'(exp_err_cnt));
    endtask

    // Called just after a falling edge: drives inputs, advances one clock, checks outputs.
    task automatic drive_cycle(input logic v, input int s, input logic [NUM_IN*WIDTH-1:0] bus,
                               input logic ordy, input string tag);
        logic   acc;
        logic   pp;
        entry_t e;
        in_valid  = v;
        sel       = SEL_W'(s);
        in_bus    = bus;
        out_ready = ordy;
        acc = v && (model_q.size() < 2);
        pp  = ordy && (model_q.size() > 0);
        if (s >= NUM_IN) begin
            e.data = '0;
            e.err  = 1'b1;
        end else begin
            e.data = bus[s*WIDTH +: WIDTH];
            e.err  = 1'b0;
        end
        @(posedge clk);
        if (pp) void'(model_q.pop_front());
        if (acc) begin
            model_q.push_back(e);
            if (e.err && exp_err_cnt < 255) exp_err_cnt++;
        end
        if (model_q.size() > 0) last_out = model_q[0].data;
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        n_checks    = 0;
        n_fails     = 0;
        exp_err_cnt = 0;
        last_out    = '0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        sel         = '0;
        in_bus      = '0;
        out_ready   = 1'b0;

        // Reset held across an edge with a valid offer: nothing may be accepted.
        @(negedge clk);
        in_valid = 1'b1;
        in_bus   = bus_of(1);
        @(posedge clk);
        #2;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready",  64'(in_ready),  64'd0);
        check("rst.out",       64'(out),       64'd0);
        check("rst.out_err",   64'(out_err),   64'd0);
        check("rst.err_cnt",   64'(err_cnt),   64'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rel.in_ready", 64'(in_ready), 64'd1);

        // Single accept of channel 2 with one-cycle latency, then drained.
        drive_cycle(1'b1, 2, bus_of(1), 1'b1, "r028_acc");
        check("r028.out", 64'(out), 64'd3);
        drive_cycle(1'b0, 0, bus_of(1), 1'b1, "r028_drain");
        check("r028.drained", 64'(out_valid), 64'd0);

        // Back-pressure fills the buffer, head held, then drained in order.
        drive_cycle(1'b1, 0, bus_of(1), 1'b0, "r029_acc0");
        drive_cycle(1'b1, 4, bus_of(1), 1'b0, "r029_acc4");
        check("r029.full", 64'(in_ready), 64'd0);
        drive_cycle(1'b1, 3, bus_of(1), 1'b0, "r029_blocked");
        check("r029.held", 64'(out), 64'd1);
        drive_cycle(1'b0, 0, bus_of(1), 1'b1, "r029_pop1");
        check("r029.second", 64'(out), 64'd5);
        drive_cycle(1'b0, 0, bus_of(1), 1'b1, "r029_pop2");
        check("r029.ready", 64'(in_ready), 64'd1);

        // Out-of-range selects yield zero data with err set and are counted.
        for (int s = 5; s <= 7; s++) drive_cycle(1'b1, s, bus_of(10), 1'b1, "r030_err");
        check("r030.err_cnt", 64'(err_cnt), 64'd3);
        drive_cycle(1'b0, 0, bus_of(10), 1'b1, "r030_drain");

        // Offers while FULL are ignored and do not count as errors.
        drive_cycle(1'b1, 1, bus_of(20), 1'b0, "r024_fill1");
        drive_cycle(1'b1, 3, bus_of(20), 1'b0, "r024_fill2");
        drive_cycle(1'b1, 7, bus_of(20), 1'b0, "r024_bad_full");
        check("r024.err_cnt", 64'(err_cnt), 64'd3);
        drive_cycle(1'b0, 0, bus_of(20), 1'b1, "r024_drain1");
        drive_cycle(1'b0, 0, bus_of(20), 1'b1, "r024_drain2");

        // Error counter saturation.
        for (int i = 0; i < 300; i++) drive_cycle(1'b1, 7, rand_bus(), 1'b1, "r031_sat");
        check("r031.err_cnt", 64'(err_cnt), 64'd255);
        drive_cycle(1'b0, 0, rand_bus(), 1'b1, "r031_drain");

        // Full throughput streaming with the buffer staying at one entry.
        for (int i = 0; i < 10; i++) begin
            drive_cycle(1'b1, i % NUM_IN, rand_bus(), 1'b1, "r032_stream");
            if (i > 0) check("r032.one_entry", 64'(in_ready && out_valid), 64'd1);
        end
        drive_cycle(1'b0, 0, rand_bus(), 1'b1, "r032_drain");

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            drive_cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), rand_bus(),
                        1'($urandom_range(0, 1)), "rand");
        end

        // Asynchronous reset while FULL, between clock edges.
        drive_cycle(1'b0, 0, rand_bus(), 1'b1, "r033_pre_drain1");
        drive_cycle(1'b0, 0, rand_bus(), 1'b1, "r033_pre_drain2");
        drive_cycle(1'b1, 1, bus_of(40), 1'b0, "r033_fill1");
        drive_cycle(1'b1, 2, bus_of(40), 1'b0, "r033_fill2");
        drive_cycle(1'b1, 7, bus_of(40), 1'b0, "r033_fill_err");
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("r033.out_valid", 64'(out_valid), 64'd0);
        check("r033.err_cnt",   64'(err_cnt),   64'd0);
        check("r033.in_ready",  64'(in_ready),  64'd0);
        check("r033.out",       64'(out),       64'd0);
        model_q.delete();
        exp_err_cnt = 0;
        last_out    = '0;
        #1;
        rst = 1'b0;
        drive_cycle(1'b1, 3, bus_of(50), 1'b0, "r033_after");
        check("r033.accepted", 64'(out), 64'd53);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_result_select.md
ALU_RESULT_SELECT -- requirements
Module: alu_result_select

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data width of each result channel and of the output.
REQ-002 SHALL have parameter NUM_IN, default 5, meaning number of input result channels (2..16).
REQ-003 SHALL have parameter SEL_W, default 3, meaning select width; SEL_W SHALL be large enough to encode NUM_IN-1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_bus, input, NUM_IN*WIDTH bits: channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH].
REQ-007 SHALL have port sel, input, SEL_W bits: channel index, sampled on accept.
REQ-008 SHALL have port in_valid, input, 1 bit: upstream offers in_bus/sel.
REQ-009 SHALL have port in_ready, output, 1 bit: block can accept this cycle.
REQ-010 SHALL have port out, output, WIDTH bits: selected result at head of buffer.
REQ-011 SHALL have port out_err, output, 1 bit: head entry was accepted with an out-of-range sel.
REQ-012 SHALL have port out_valid, output, 1 bit: out/out_err hold a valid entry.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream consumes the head entry.
REQ-014 SHALL have port err_cnt, output, 8 bits: saturating count of accepted out-of-range selects.

Function
REQ-015 Accept SHALL occur when in_valid && in_ready at a rising clk edge; pop SHALL occur when out_valid && out_ready.
REQ-016 On accept, the entry SHALL capture in_bus channel sel; if sel >= NUM_IN, the data SHALL be all-zero and the entry's err bit SHALL be 1.
REQ-017 Buffer SHALL be 2 entries, FIFO order, states EMPTY, ONE, FULL.
REQ-018 Transitions: EMPTY+accept -> ONE; ONE+accept only -> FULL; ONE+pop only -> EMPTY; ONE+accept+pop -> ONE (head replaced by new entry); FULL+pop -> ONE (second entry becomes head); all other cases hold state.
REQ-019 in_ready SHALL be 1 exactly when state != FULL; it SHALL depend only on registered state, not on out_ready.
REQ-020 out_valid SHALL be 1 exactly when state != EMPTY; out/out_err SHALL reflect the head entry and SHALL NOT change while out_valid=1 and out_ready=0.
REQ-021 Latency from accept to out_valid SHALL be one cycle; sustained throughput SHALL be one entry per cycle when out_ready stays 1.
REQ-022 When out_valid=0, out SHALL hold its last value and out_err SHALL be 0.
REQ-023 err_cnt SHALL increment by 1 on each accept with sel >= NUM_IN and SHALL saturate at 255.
REQ-024 Inputs offered while in_ready=0 SHALL be ignored and SHALL NOT affect err_cnt.

Reset
REQ-025 While rst=1, state SHALL be EMPTY, out=0, out_err=0, out_valid=0, err_cnt=0, and in_ready=0; the accept condition SHALL never be true.
REQ-026 Assertion of rst mid-transfer SHALL discard all buffered entries immediately without waiting for clk.
REQ-027 On the first clk edge after rst deasserts, in_ready SHALL be 1 and the block SHALL accept normally.

Verification
REQ-028 Reset then in_bus channels {1,2,3,4,5}, sel=2, in_valid=1 for one cycle, out_ready=1 -> next cycle out=3, out_valid=1, out_err=0; cycle after, out_valid=0.
REQ-029 out_ready=0, accept sel=0 then sel=4 -> in_ready=0 after second accept, out=1 held; raise out_ready -> out=1 then out=5 on consecutive cycles, then in_ready=1.
REQ-030 Accept sel=5, sel=6, sel=7 -> each entry out=0, out_err=1; err_cnt=3.
REQ-031 300 accepts with sel=7 -> err_cnt=255 and stays 255.
REQ-032 Continuous in_valid=1, out_ready=1, sel cycling 0..4 for 10 cycles -> one output per cycle, order preserved, state stays ONE.
REQ-033 Buffer FULL, pulse rst asynchronously between clk edges -> out_valid=0, err_cnt=0 immediately; first edge after release accepts new entry.
